pr_bus_arbiter: RTL and testbench
=================================

PR_BUS_ARBITER -- requirements
Module: pr_bus_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 m0_req  input  1  CPU MEM-stage bus request; m0_we  input  1  write; m0_addr  input  30  word address [31:2]; m0_wd  input  32  write data.
REQ-004 m0_ack  output  1  one-cycle completion pulse; m0_rd  output  32  read data, valid with m0_ack; m0_err  output  1  error flag, valid with m0_ack.
REQ-005 m1_req, m1_we, m1_addr[29:0], m1_wd[31:0]  inputs; m1_ack, m1_rd[31:0], m1_err  outputs; same meanings as m0_* for the DMA/debug requester.
REQ-006 dev_addr  output  30  shared device word address; dev_wd  output  32  shared write data; dev_we  output  1  write strobe; dev_sel  output  2  one-hot device select (bit0 timer, bit1 IO).
REQ-007 dev0_rd, dev1_rd  input  32  device read data; dev0_ready, dev1_ready  input  1  device completion.
REQ-008 m0_stall  output  1  high while an m0 request is pending and not yet acked; drives pipeline stall.

Function
REQ-009 States SHALL be IDLE, BUSY0 (serving m0), BUSY1 (serving m1); state register 2 bits.
REQ-010 Decode SHALL be: byte addr 0x0000_7F00-0x0000_7F0F -> dev 0; 0x0000_7F10-0x0000_7F1F -> dev 1; any other address unmapped.
REQ-011 In IDLE with m0_req only, or both requests and starve_cnt < 4, grant SHALL go to m0; otherwise to m1 if m1_req.
REQ-012 starve_cnt (3 bits) SHALL increment, saturating at 4, each IDLE cycle where m1_req is high and m1 is not granted; clear to 0 when m1 is granted.
REQ-013 On grant to a mapped address, the arbiter SHALL latch requester addr/wd/we into the bus registers and enter BUSYx next cycle; dev_sel/dev_addr/dev_wd/dev_we SHALL be driven only from these registers while in BUSYx, otherwise dev_sel=0, dev_we=0.
REQ-014 On grant to an unmapped address, no BUSY state SHALL be entered; the requester's ack SHALL pulse on the following cycle with rd=0, err=1; device outputs stay idle.
REQ-015 In BUSYx, when the selected device's ready is high, the requester SHALL receive ack=1 the next cycle with rd = registered device read data (0 on writes), err=0; state returns to IDLE in that same cycle as the ack.
REQ-016 A wait counter (4 bits) SHALL count BUSY cycles; if ready has not arrived after 15 BUSY cycles, the transaction SHALL abort: ack next cycle, rd=0, err=1, return to IDLE.
REQ-017 dev_we SHALL be high for exactly one BUSY cycle (the first) on writes, preventing duplicate device writes during wait states.
REQ-018 Minimum mapped latency SHALL be 3 cycles from req to ack (grant, BUSY with ready, ack); requests SHALL be held by the requester until ack; a req dropped before ack is a protocol violation, no defined behaviour.
REQ-019 A new grant SHALL not occur in the cycle an ack is issued; the earliest next grant is the cycle after ack.
REQ-020 ready from the non-selected device SHALL be ignored.
REQ-021 m0_stall SHALL equal m0_req AND NOT m0_ack, combinationally.
REQ-022 Only one of m0_ack, m1_ack SHALL be high in any cycle.

Reset
REQ-023 With rst=0 at a clk edge: state=IDLE, starve_cnt=0, wait counter=0, bus registers=0; all acks, errs, rd outputs, dev_sel, dev_we = 0 next cycle.
REQ-024 Reset asserted mid-transaction SHALL abandon it without ack; a device ready arriving after reset SHALL be ignored.

Verification
REQ-025 m0 read 0x7F04, dev0_ready in first BUSY cycle with dev0_rd=0x1234_5678 -> m0_ack 3 cycles after req, m0_rd=0x1234_5678, m0_err=0.
REQ-026 m0 and m1 both requesting continuously, each device ready immediately -> m1 granted after 4 consecutive m0 grants' worth of starve cycles, then starve_cnt=0.
REQ-027 m1 write to 0x7F14 wd=0xA5A5_A5A5, dev1_ready after 5 cycles -> dev_sel=2'b10, dev_we high exactly 1 cycle, m1_ack once, m1_err=0.
REQ-028 m0 read 0x0000_1000 (unmapped) -> m0_ack next cycle, m0_rd=0, m0_err=1, dev_sel stays 0.
REQ-029 m0 read 0x7F00 with dev0_ready never asserted -> m0_ack after 15 BUSY cycles, m0_err=1, m0_stall high until then.
REQ-030 rst=0 during BUSY1, dev1_ready asserted the next cycle -> no m1_ack, state IDLE, all outputs 0.

Source files
------------

// File: rtl/pr_bus_arbiter_if.sv
// Signal bundle shared by the two requesters, the arbiter and the two devices.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (CPU MEM stage, DMA/debug port, timer and IO devices).
interface pr_bus_arbiter_if;
  // Requester 0: CPU MEM stage
  logic        m0_req;
  logic        m0_we;
  logic [29:0] m0_addr;
  logic [31:0] m0_wd;
  logic        m0_ack;
  logic [31:0] m0_rd;
  logic        m0_err;
  logic        m0_stall;

  // Requester 1: DMA / debug
  logic        m1_req;
  logic        m1_we;
  logic [29:0] m1_addr;
  logic [31:0] m1_wd;
  logic        m1_ack;
  logic [31:0] m1_rd;
  logic        m1_err;

  // Shared device bus (sel bit0 = timer, bit1 = IO)
  logic [29:0] dev_addr;
  logic [31:0] dev_wd;
  logic        dev_we;
  logic [1:0]  dev_sel;
  logic [31:0] dev0_rd;
  logic [31:0] dev1_rd;
  logic        dev0_ready;
  logic        dev1_ready;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    output m0_ack, m0_rd, m0_err, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_wd,
    output m1_ack, m1_rd, m1_err,
    output dev_addr, dev_wd, dev_we, dev_sel,
    input  dev0_rd, dev1_rd, dev0_ready, dev1_ready
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    input  m0_ack, m0_rd, m0_err, m0_stall,
    output m1_req, m1_we, m1_addr, m1_wd,
    input  m1_ack, m1_rd, m1_err,
    input  dev_addr, dev_wd, dev_we, dev_sel,
    output dev0_rd, dev1_rd, dev0_ready, dev1_ready
  );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Two-requester bus arbiter for the timer/IO device window.
// m0 (CPU) normally wins; m1 (DMA/debug) wins once it has waited 4 idle
// cycles. Mapped accesses run IDLE -> BUSYx -> ack; unmapped accesses and
// transactions whose device never answers within 15 busy cycles ack with err.
module pr_bus_arbiter (
  input  logic            clk,
  input  logic            rst,   // synchronous, active low
  pr_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_e;

  // Word-address pages (byte address >> 4) of the two 16-byte device windows.
  localparam logic [27:0] DEV0_PAGE  = 28'h00007F0;
  localparam logic [27:0] DEV1_PAGE  = 28'h00007F1;
  localparam logic [2:0]  STARVE_MAX = 3'd4;
  // wait counter value in the 15th busy cycle; no ready by then means abort
  localparam logic [3:0]  WAIT_LAST  = 4'd14;

  // One-hot device select for a word address, 2'b00 when unmapped.
  function automatic logic [1:0] decode(input logic [29:0] addr);
    logic [1:0] sel;
    sel = 2'b00;
    if (addr[29:2] == DEV0_PAGE)      sel = 2'b01;
    else if (addr[29:2] == DEV1_PAGE) sel = 2'b10;
    return sel;
  endfunction

  state_e      state_q,  state_d;
  logic [2:0]  starve_q, starve_d;
  logic [3:0]  wait_q,   wait_d;
  logic [29:0] addr_q,   addr_d;
  logic [31:0] wd_q,     wd_d;
  logic        we_q,     we_d;
  logic        ack0_q,   ack0_d;
  logic        ack1_q,   ack1_d;
  logic        err_q,    err_d;
  logic [31:0] rd_q,     rd_d;

  logic        busy;
  logic [1:0]  busy_sel;
  logic        busy_ready;
  logic [31:0] busy_rd;
  logic [1:0]  m0_sel;
  logic [1:0]  m1_sel;
  logic        grant0;
  logic        grant1;

  // The latched address is always mapped while busy, so it names the device;
  // the other device's ready and read data are never looked at.
  assign busy       = (state_q != IDLE);
  assign busy_sel   = decode(addr_q);
  assign busy_ready = |(busy_sel & {bus.dev1_ready, bus.dev0_ready});
  assign busy_rd    = busy_sel[1] ? bus.dev1_rd : bus.dev0_rd;
  assign m0_sel     = decode(bus.m0_addr);
  assign m1_sel     = decode(bus.m1_addr);

  // Arbitration: only from IDLE and never in an ack cycle; m1 wins once starved.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !ack0_q && !ack1_q) begin
      if (bus.m0_req && (!bus.m1_req || starve_q < STARVE_MAX)) grant0 = 1'b1;
      else if (bus.m1_req)                                     grant1 = 1'b1;
    end
  end

  // Next state, starvation/wait counters, bus registers and ack/response.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    we_d     = we_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    rd_d     = '0;

    unique case (state_q)
      IDLE: begin
        wait_d = '0;
        if (grant1)                                    starve_d = '0;
        else if (bus.m1_req && starve_q != STARVE_MAX) starve_d = starve_q + 3'd1;

        if (grant0) begin
          if (m0_sel != 2'b00) begin
            addr_d  = bus.m0_addr;
            wd_d    = bus.m0_wd;
            we_d    = bus.m0_we;
            state_d = BUSY0;
          end else begin
            ack0_d = 1'b1;
            err_d  = 1'b1;
          end
        end else if (grant1) begin
          if (m1_sel != 2'b00) begin
            addr_d  = bus.m1_addr;
            wd_d    = bus.m1_wd;
            we_d    = bus.m1_we;
            state_d = BUSY1;
          end else begin
            ack1_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      BUSY0, BUSY1: begin
        if (busy_ready || wait_q == WAIT_LAST) begin
          state_d = IDLE;
          wait_d  = '0;
          ack0_d  = (state_q == BUSY0);
          ack1_d  = (state_q == BUSY1);
          if (busy_ready) rd_d  = we_q ? '0 : busy_rd;
          else            err_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // Responses are gated by their own ack so only the acked requester sees data.
  assign bus.m0_ack   = ack0_q;
  assign bus.m0_rd    = ack0_q ? rd_q : '0;
  assign bus.m0_err   = ack0_q & err_q;
  assign bus.m0_stall = bus.m0_req & ~ack0_q;

  assign bus.m1_ack   = ack1_q;
  assign bus.m1_rd    = ack1_q ? rd_q : '0;
  assign bus.m1_err   = ack1_q & err_q;

  // Device bus is driven from the bus registers only while busy; the write
  // strobe is limited to the first busy cycle so wait states never re-write.
  assign bus.dev_sel  = busy ? busy_sel : 2'b00;
  assign bus.dev_addr = busy ? addr_q : '0;
  assign bus.dev_wd   = busy ? wd_q : '0;
  assign bus.dev_we   = busy & we_q & (wait_q == 4'd0);

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench for pr_bus_arbiter: reset values, a table of isolated
// transactions, starvation and reset-abandon sequences, then random traffic
// against a transaction-level model of the arbitration rules.
module tb_pr_bus_arbiter;

  logic clk = 1'b0;
  logic rst;

  pr_bus_arbiter_if bus ();

  pr_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // One isolated transaction and what it must produce.
  typedef struct {
    int          m;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wd;
    int          rdy_dev;  // device that answers (the other one is ready constantly)
    int          d;        // busy-cycle index of ready; >14 means never in time
    logic [31:0] drd;
    int          e_lat;    // cycles from request cycle to ack cycle
    logic [31:0] e_rd;
    logic        e_err;
    logic [1:0]  e_sel;
    int          e_we;     // number of cycles dev_we is high
  } vec_t;

  vec_t vecs [10];

  // Random-traffic model state.
  typedef struct {
    logic        active;
    logic        granted;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wd;
    int          ack_cycle;
  } rq_t;

  rq_t         rq [2];
  int          cur_m, cur_dev, busy_start, ack_cyc, dly, free_at, starve;
  logic        cur_mapped, cur_we, cur_err, busy_now, e_ack0, e_ack1, g0, g1;
  logic        rdy0, rdy1;
  logic [31:0] rdv0, rdv1, cur_data, cur_rd, cur_wd;
  logic [29:0] cur_addr;

  int          lat_o, we_o, bad_o;
  logic [31:0] rd_o;
  logic        err_o;
  logic [1:0]  sel_o;

  int          ack_c [8];
  int          ack_m [8];
  int          n_acks, n_both;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // NOTE: stimulus is driven with blocking assignments just after the edge,
  // so the DUT sees stable inputs well before the next sampling edge.
  task automatic drive_req(input int m, input logic req, input logic we,
                           input logic [29:0] a, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wd = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wd = wd;
    end
  endtask

  task automatic set_dev(input logic r0, input logic r1, input logic [31:0] d0, input logic [31:0] d1);
    bus.dev0_ready = r0; bus.dev1_ready = r1; bus.dev0_rd = d0; bus.dev1_rd = d1;
  endtask

  task automatic drive_idle();
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    set_dev(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // Reference decode from byte addresses: device index or -1 when unmapped.
  function automatic int dev_of(input logic [29:0] a);
    logic [31:0] b;
    b = {a, 2'b00};
    if (b >= 32'h0000_7F00 && b <= 32'h0000_7F1F) return int'((b - 32'h0000_7F00) / 16);
    return -1;
  endfunction

  // Run one transaction alone on the bus; the idle device keeps ready high.
  task automatic run_txn(input vec_t v, output int lat, output logic [31:0] rd, output logic err,
                         output logic [1:0] sel_or, output int we_cnt, output int proto_bad);
    logic ack, other_ack, hit;
    lat = -1; rd = '0; err = 1'b0; sel_or = 2'b00; we_cnt = 0; proto_bad = 0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      drive_req(v.m, 1'b1, v.we, v.addr, v.wd);
      drive_req(1 - v.m, 1'b0, 1'b0, '0, '0);
      hit = (c == v.d + 1);
      if (v.rdy_dev == 0) set_dev(hit, 1'b1, hit ? v.drd : 32'h0BAD_0BAD, 32'hDEAD_BEEF);
      else                set_dev(1'b1, hit, 32'hDEAD_BEEF, hit ? v.drd : 32'h0BAD_0BAD);
      #1;
      sel_or |= bus.dev_sel;
      if (bus.dev_we) we_cnt++;
      ack       = (v.m == 0) ? bus.m0_ack : bus.m1_ack;
      other_ack = (v.m == 0) ? bus.m1_ack : bus.m0_ack;
      if (other_ack) proto_bad++;
      if (bus.m0_stall !== ((v.m == 0) && !ack)) proto_bad++;
      if (ack) begin
        lat = c;
        rd  = (v.m == 0) ? bus.m0_rd  : bus.m1_rd;
        err = (v.m == 0) ? bus.m0_err : bus.m1_err;
      end
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{m:0, we:1'b0, addr:30'h0000_1FC1, wd:32'h0,         rdy_dev:0, d:0,  drd:32'h1234_5678,
                e_lat:2,  e_rd:32'h1234_5678, e_err:1'b0, e_sel:2'b01, e_we:0};
    vecs[1] = '{m:1, we:1'b1, addr:30'h0000_1FC5, wd:32'hA5A5_A5A5, rdy_dev:1, d:5,  drd:32'hFFFF_0000,
                e_lat:7,  e_rd:32'h0,         e_err:1'b0, e_sel:2'b10, e_we:1};
    vecs[2] = '{m:0, we:1'b0, addr:30'h0000_0400, wd:32'h0,         rdy_dev:0, d:99, drd:32'h0,
                e_lat:1,  e_rd:32'h0,         e_err:1'b1, e_sel:2'b00, e_we:0};
    vecs[3] = '{m:0, we:1'b0, addr:30'h0000_1FC0, wd:32'h0,         rdy_dev:0, d:99, drd:32'h0,
                e_lat:16, e_rd:32'h0,         e_err:1'b1, e_sel:2'b01, e_we:0};
    vecs[4] = '{m:1, we:1'b0, addr:30'h0000_1FC3, wd:32'h0,         rdy_dev:0, d:14, drd:32'hCAFE_F00D,
                e_lat:16, e_rd:32'hCAFE_F00D, e_err:1'b0, e_sel:2'b01, e_we:0};
    vecs[5] = '{m:0, we:1'b1, addr:30'h0000_1FC4, wd:32'h1122_3344, rdy_dev:1, d:15, drd:32'h0,
                e_lat:16, e_rd:32'h0,         e_err:1'b1, e_sel:2'b10, e_we:1};
    vecs[6] = '{m:1, we:1'b1, addr:30'h0000_1FBF, wd:32'h5555_AAAA, rdy_dev:0, d:99, drd:32'h0,
                e_lat:1,  e_rd:32'h0,         e_err:1'b1, e_sel:2'b00, e_we:0};
    vecs[7] = '{m:0, we:1'b0, addr:30'h0000_1FC8, wd:32'h0,         rdy_dev:0, d:99, drd:32'h0,
                e_lat:1,  e_rd:32'h0,         e_err:1'b1, e_sel:2'b00, e_we:0};
    vecs[8] = '{m:0, we:1'b0, addr:30'h0000_1FC7, wd:32'h0,         rdy_dev:1, d:2,  drd:32'h0F0F_0F0F,
                e_lat:4,  e_rd:32'h0F0F_0F0F, e_err:1'b0, e_sel:2'b10, e_we:0};
    vecs[9] = '{m:1, we:1'b0, addr:30'h2000_1FC0, wd:32'h0,         rdy_dev:0, d:99, drd:32'h0,
                e_lat:1,  e_rd:32'h0,         e_err:1'b1, e_sel:2'b00, e_we:0};

    // Reset values.
    rst = 1'b0;
    drive_idle();
    next_cycle();
    next_cycle();
    check("reset_m0_ack",  32'(bus.m0_ack),  32'd0);
    check("reset_m1_ack",  32'(bus.m1_ack),  32'd0);
    check("reset_m0_rd",   bus.m0_rd,        32'd0);
    check("reset_m1_rd",   bus.m1_rd,        32'd0);
    check("reset_m0_err",  32'(bus.m0_err),  32'd0);
    check("reset_m1_err",  32'(bus.m1_err),  32'd0);
    check("reset_dev_sel", 32'(bus.dev_sel), 32'd0);
    check("reset_dev_we",  32'(bus.dev_we),  32'd0);
    check("reset_stall",   32'(bus.m0_stall), 32'd0);
    rst = 1'b1;
    next_cycle();

    // Table of isolated transactions.
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], lat_o, rd_o, err_o, sel_o, we_o, bad_o);
      check($sformatf("vec%0d_latency", i),  32'(lat_o), 32'(vecs[i].e_lat));
      check($sformatf("vec%0d_rd", i),       rd_o,       vecs[i].e_rd);
      check($sformatf("vec%0d_err", i),      32'(err_o), 32'(vecs[i].e_err));
      check($sformatf("vec%0d_dev_sel", i),  32'(sel_o), 32'(vecs[i].e_sel));
      check($sformatf("vec%0d_we_cycles", i), 32'(we_o), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_protocol", i), 32'(bad_o), 32'd0);
      next_cycle();
      next_cycle();
    end

    // Both requesters hold requests, both devices always ready: m1 wins each
    // time its starvation count has reached 4.
    do_reset();
    n_acks = 0;
    n_both = 0;
    for (int i = 0; i < 8; i++) begin ack_c[i] = -1; ack_m[i] = -1; end
    for (int c = 0; c < 19; c++) begin
      drive_req(0, 1'b1, 1'b0, 30'h0000_1FC0, '0);
      drive_req(1, 1'b1, 1'b0, 30'h0000_1FC4, '0);
      set_dev(1'b1, 1'b1, 32'h0000_00AA, 32'h0000_00BB);
      #1;
      if (bus.m0_ack && bus.m1_ack) n_both++;
      if ((bus.m0_ack || bus.m1_ack) && n_acks < 8) begin
        ack_c[n_acks] = c;
        ack_m[n_acks] = bus.m1_ack ? 1 : 0;
        n_acks++;
      end
      next_cycle();
    end
    drive_idle();
    check("starve_ack_count", 32'(n_acks), 32'd6);
    check("starve_both_acks", 32'(n_both), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_ack%0d_cycle", i),  32'(ack_c[i]), 32'(2 + 3 * i));
      check($sformatf("starve_ack%0d_master", i), 32'(ack_m[i]), (i % 3 == 2) ? 32'd1 : 32'd0);
    end

    // Reset in BUSY1 abandons the transaction; a late ready is ignored.
    do_reset();
    drive_req(1, 1'b1, 1'b0, 30'h0000_1FC4, '0);
    next_cycle();
    #1;
    check("rstmid_busy1_sel", 32'(bus.dev_sel), 32'd2);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    drive_idle();
    set_dev(1'b0, 1'b1, '0, 32'h7777_7777);
    #1;
    check("rstmid_dev_sel", 32'(bus.dev_sel), 32'd0);
    check("rstmid_dev_we",  32'(bus.dev_we),  32'd0);
    check("rstmid_m1_ack",  32'(bus.m1_ack),  32'd0);
    check("rstmid_m1_rd",   bus.m1_rd,        32'd0);
    next_cycle();
    set_dev(1'b0, 1'b0, '0, '0);
    n_acks = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.m0_ack || bus.m1_ack || bus.m1_err || bus.dev_sel != 2'b00) n_acks++;
      next_cycle();
    end
    check("rstmid_quiet_after", 32'(n_acks), 32'd0);

    // Random traffic against the transaction-level model.
    do_reset();
    for (int m = 0; m < 2; m++) rq[m] = '{active:1'b0, granted:1'b0, we:1'b0, addr:'0, wd:'0, ack_cycle:0};
    cur_m = -1; cur_dev = -1; cur_mapped = 1'b0; cur_we = 1'b0; cur_err = 1'b0;
    busy_start = 0; ack_cyc = -1; dly = 0; free_at = 0; starve = 0;
    cur_data = '0; cur_rd = '0; cur_wd = '0; cur_addr = '0;
    for (int t = 0; t < 3000; t++) begin
      // requesters: hold until the expected ack, then maybe start a new one
      for (int m = 0; m < 2; m++) begin
        if (rq[m].active && rq[m].granted && t > rq[m].ack_cycle) rq[m].active = 1'b0;
        if (!rq[m].active && $urandom_range(3) == 0) begin
          rq[m].active  = 1'b1;
          rq[m].granted = 1'b0;
          rq[m].we      = 1'($urandom_range(1));
          rq[m].wd      = $urandom;
          case ($urandom_range(7))
            0, 1, 2: rq[m].addr = 30'h0000_1FC0 + 30'($urandom_range(3));
            3, 4, 5: rq[m].addr = 30'h0000_1FC4 + 30'($urandom_range(3));
            6:       rq[m].addr = ($urandom_range(1) == 0) ? 30'h0000_1FBF : 30'h0000_1FC8;
            default: rq[m].addr = 30'($urandom);
          endcase
        end
        drive_req(m, rq[m].active, rq[m].we, rq[m].addr, rq[m].wd);
      end
      // devices: noise everywhere except the selected device during busy cycles
      busy_now = (cur_m >= 0) && cur_mapped && t >= busy_start && t < ack_cyc;
      rdy0 = 1'($urandom_range(1)); rdy1 = 1'($urandom_range(1));
      rdv0 = $urandom;              rdv1 = $urandom;
      if (busy_now) begin
        if (cur_dev == 0) begin
          rdy0 = (t - busy_start == dly);
          if (rdy0) rdv0 = cur_data;
        end else begin
          rdy1 = (t - busy_start == dly);
          if (rdy1) rdv1 = cur_data;
        end
      end
      set_dev(rdy0, rdy1, rdv0, rdv1);
      #1;
      e_ack0 = (cur_m == 0) && (t == ack_cyc);
      e_ack1 = (cur_m == 1) && (t == ack_cyc);
      check("rand_m0_ack", 32'(bus.m0_ack), 32'(e_ack0));
      check("rand_m1_ack", 32'(bus.m1_ack), 32'(e_ack1));
      check("rand_m0_rd",  bus.m0_rd, e_ack0 ? cur_rd : 32'd0);
      check("rand_m1_rd",  bus.m1_rd, e_ack1 ? cur_rd : 32'd0);
      check("rand_m0_err", 32'(bus.m0_err), 32'(e_ack0 && cur_err));
      check("rand_m1_err", 32'(bus.m1_err), 32'(e_ack1 && cur_err));
      check("rand_dev_sel", 32'(bus.dev_sel), busy_now ? ((cur_dev == 0) ? 32'd1 : 32'd2) : 32'd0);
      check("rand_dev_we",  32'(bus.dev_we), 32'(busy_now && t == busy_start && cur_we));
      check("rand_dev_addr", 32'(bus.dev_addr), busy_now ? 32'(cur_addr) : 32'd0);
      check("rand_dev_wd",   bus.dev_wd, busy_now ? cur_wd : 32'd0);
      check("rand_m0_stall", 32'(bus.m0_stall), 32'(rq[0].active && !e_ack0));
      // arbitration for this cycle
      g0 = 1'b0;
      g1 = 1'b0;
      if (t >= free_at) begin
        g0 = rq[0].active && (!rq[1].active || starve < 4);
        g1 = !g0 && rq[1].active;
      end
      if (!busy_now) begin
        if (g1)                starve = 0;
        else if (rq[1].active) starve = (starve >= 4) ? 4 : starve + 1;
      end
      if (g0 || g1) begin
        cur_m      = g0 ? 0 : 1;
        cur_dev    = dev_of(rq[cur_m].addr);
        cur_mapped = (cur_dev >= 0);
        cur_we     = rq[cur_m].we;
        cur_addr   = rq[cur_m].addr;
        cur_wd     = rq[cur_m].wd;
        busy_start = t + 1;
        if (cur_mapped) begin
          dly      = int'($urandom_range(17));
          cur_data = $urandom;
          cur_err  = (dly > 14);
          ack_cyc  = t + 2 + ((dly > 14) ? 14 : dly);
          cur_rd   = (cur_err || cur_we) ? 32'd0 : cur_data;
        end else begin
          cur_err  = 1'b1;
          ack_cyc  = t + 1;
          cur_rd   = 32'd0;
        end
        rq[cur_m].granted   = 1'b1;
        rq[cur_m].ack_cycle = ack_cyc;
        free_at             = ack_cyc + 1;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
